cyclic_state_sequencer: RTL and testbench

Parametrised successor to the fixed six-state cyclic state machine. It steps through NUM_STATES encoded states and adds features the fixed version lacks:
- per-state dwell count
- run enable
- forward/reverse direction
- synchronous load of an arbitrary state
- a wrap pulse and a load-error pulse

It sits as a sequence/phase generator driving downstream control logic from state_out.

---
 rtl/cyclic_state_sequencer_if.sv | 30 +++
 rtl/cyclic_state_sequencer.sv | 95 +++++++++
 tb/tb_cyclic_state_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cyclic_state_sequencer_if.sv
// Control/status bundle for cyclic_state_sequencer.
// Latency: none, plain wires grouped for port hookup.
// Backpressure: none; en is the only flow control, and it freezes the sequencer.
//
// Signals:
//   en, dir, load, load_state, dwell : driven by the controlling block (master)
//   state_out, wrap, load_err        : driven by the sequencer (slave)
interface cyclic_state_sequencer_if #(
    parameter int STATE_W = 3,
    parameter int DWELL_W = 4
);
    logic               en;
    logic               dir;
    logic               load;
    logic [STATE_W-1:0] load_state;
    logic [DWELL_W-1:0] dwell;
    logic [STATE_W-1:0] state_out;
    logic               wrap;
    logic               load_err;

    modport master (
        output en, dir, load, load_state, dwell,
        input  state_out, wrap, load_err
    );

    modport slave (
        input  en, dir, load, load_state, dwell,
        output state_out, wrap, load_err
    );
endinterface

// File: rtl/cyclic_state_sequencer.sv
// Cyclic phase generator: steps through NUM_STATES states, with a programmable dwell per state.
// Latency: state/wrap/load_err are registered and change one cycle after the causing edge.
// Backpressure: en=0 freezes the state and the dwell counter. load takes priority over en.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears state, dwell counter and pulses
//   seq   : slave side of cyclic_state_sequencer_if (en/dir/load/load_state/dwell in,
//           state_out/wrap/load_err out)
module cyclic_state_sequencer #(
    parameter int NUM_STATES = 6,
    parameter int STATE_W    = 3,
    parameter int DWELL_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    cyclic_state_sequencer_if.slave   seq
);

    // One extra bit lets NUM_STATES == 2**STATE_W be compared without overflow.
    localparam logic [STATE_W:0]   NUM_EXT = (STATE_W+1)'(NUM_STATES);
    localparam logic [STATE_W-1:0] LAST_ST = STATE_W'(NUM_STATES - 1);

    logic [STATE_W-1:0] state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               wrap_q;
    logic               load_err_q;

    logic [STATE_W-1:0] adv_state;
    logic               adv_wrap;
    logic               load_ok;

    assign load_ok = ({1'b0, seq.load_state} < NUM_EXT);

    // Successor state for an advancing edge. An out-of-range current state
    // (reachable only through upsets) always recovers to 0 as a wrap.
    always_comb begin
        adv_state = '0;
        adv_wrap  = 1'b0;
        if ({1'b0, state_q} >= NUM_EXT) begin
            adv_state = '0;
            adv_wrap  = 1'b1;
        end else if (!seq.dir) begin
            if (state_q == LAST_ST) begin
                adv_state = '0;
                adv_wrap  = 1'b1;
            end else begin
                adv_state = state_q + STATE_W'(1);
            end
        end else begin
            if (state_q == '0) begin
                adv_state = LAST_ST;
                adv_wrap  = 1'b1;
            end else begin
                adv_state = state_q - STATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // Both flags are single-cycle pulses unless their trigger repeats.
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (seq.load) begin
                if (load_ok) begin
                    state_q <= seq.load_state;
                    cnt_q   <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (seq.en) begin
                // >= rather than == so that lowering dwell mid-state
                // forces an advance instead of counting all the way round.
                if (cnt_q >= seq.dwell) begin
                    state_q <= adv_state;
                    cnt_q   <= '0;
                    wrap_q  <= adv_wrap;
                end else begin
                    cnt_q <= cnt_q + DWELL_W'(1);
                end
            end
        end
    end

    assign seq.state_out = state_q;
    assign seq.wrap      = wrap_q;
    assign seq.load_err  = load_err_q;

endmodule

// File: tb/tb_cyclic_state_sequencer.sv
// Directed bench for cyclic_state_sequencer (NUM_STATES=6, STATE_W=3, DWELL_W=4).
// Inputs are driven 1 ns after each rising edge; outputs are checked at the same point.
// Expected values come from the hand-computed directed sequence below.
module tb_cyclic_state_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   rev_st [7] = '{5, 4, 3, 2, 1, 0, 5};
    logic rev_wr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    cyclic_state_sequencer_if #(.STATE_W(3), .DWELL_W(4)) seq_if ();

    cyclic_state_sequencer #(
        .NUM_STATES (6),
        .STATE_W    (3),
        .DWELL_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic ew, input logic el);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {seq_if.state_out, seq_if.wrap, seq_if.load_err};
        exp = {es, ew, el};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got state=%0d wrap=%b load_err=%b, expected state=%0d wrap=%b load_err=%b",
                   tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        seq_if.en         = 1'b0;
        seq_if.dir        = 1'b0;
        seq_if.load       = 1'b0;
        seq_if.load_state = 3'd0;
        seq_if.dwell      = 4'd0;

        // Reset state
        step();
        step();
        chk("reset", 3'd0, 1'b0, 1'b0);

        // Forward, dwell=0: 1,2,3,4,5,0(wrap),1,2
        reset     = 1'b0;
        seq_if.en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("fwd_dwell0", 3'(k % 6), (k == 6), 1'b0);
        end

        // Load 0, then dwell=2: each state lasts 3 cycles, wrap only on 5->0
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd0;
        step();
        chk("load0", 3'd0, 1'b0, 1'b0);
        seq_if.load  = 1'b0;
        seq_if.dwell = 4'd2;
        for (int k = 1; k <= 18; k++) begin
            step();
            chk("fwd_dwell2", 3'((k / 3) % 6), (k == 18), 1'b0);
        end

        // Reverse, dwell=0 from state 0: 5w,4,3,2,1,0,5w
        seq_if.dir   = 1'b1;
        seq_if.dwell = 4'd0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("rev_dwell0", 3'(rev_st[k]), rev_wr[k], 1'b0);
        end

        // dwell=3; at counter=1 load 4, state then held 4 cycles total
        seq_if.dir   = 1'b0;
        seq_if.dwell = 4'd3;
        step();
        chk("pre_load_cnt1", 3'd5, 1'b0, 1'b0);
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd4;
        step();
        chk("load4", 3'd4, 1'b0, 1'b0);
        seq_if.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold4", 3'd4, 1'b0, 1'b0);
        end
        // Illegal load (7): state and counter(=3) kept, load_err pulse
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd7;
        step();
        chk("load7_err", 3'd4, 1'b0, 1'b1);
        seq_if.load = 1'b0;
        step();
        chk("after_err_adv", 3'd5, 1'b0, 1'b0);
        // Boundary: 6 is illegal, 5 is legal
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd6;
        step();
        chk("load6_err", 3'd5, 1'b0, 1'b1);
        seq_if.load_state = 3'd5;
        step();
        chk("load5_ok", 3'd5, 1'b0, 1'b0);
        seq_if.load = 1'b0;

        // dwell=5; at counter=3 lower dwell to 1 -> advance on next edge
        seq_if.dwell = 4'd5;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("dwell5_count", 3'd5, 1'b0, 1'b0);
        end
        seq_if.dwell = 4'd1;
        step();
        chk("dwell_drop_adv", 3'd0, 1'b1, 1'b0);

        // dwell=2; freeze mid-dwell for 4 cycles, then resume
        seq_if.dwell = 4'd2;
        step();
        chk("pre_freeze", 3'd0, 1'b0, 1'b0);
        seq_if.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("frozen", 3'd0, 1'b0, 1'b0);
        end
        seq_if.en = 1'b1;
        step();
        chk("resume_cnt2", 3'd0, 1'b0, 1'b0);
        step();
        chk("resume_adv", 3'd1, 1'b0, 1'b0);

        // Reach state 3 with counter=2, then reset while load is requested
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd3;
        step();
        chk("load3", 3'd3, 1'b0, 1'b0);
        seq_if.load = 1'b0;
        step();
        chk("s3_cnt1", 3'd3, 1'b0, 1'b0);
        step();
        chk("s3_cnt2", 3'd3, 1'b0, 1'b0);
        reset             = 1'b1;
        seq_if.load       = 1'b1;
        seq_if.load_state = 3'd4;
        step();
        chk("reset_over_load", 3'd0, 1'b0, 1'b0);
        reset       = 1'b0;
        seq_if.load = 1'b0;
        step();
        chk("post_reset_cnt1", 3'd0, 1'b0, 1'b0);
        step();
        chk("post_reset_cnt2", 3'd0, 1'b0, 1'b0);
        step();
        chk("post_reset_adv", 3'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
